// File: rtl/ram_fill_verify_ctrl.sv
// Port-B fill/verify sequencer for the shared dual-port RAM.
// Fills base..base+N-1 with {seed+i, TAG}, optionally reads the range back and
// compares each word, then reports done/pass/error count/first failing address.
module ram_fill_verify_ctrl #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1,
  parameter logic [7:0]  TAG      = 8'hE8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic [7:0]        seed_i,
  input  logic              verify_en_i,
  output logic [DATA_W-1:0] data_b_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic              we_b_o,
  input  logic [DATA_W-1:0] q_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W:0]   err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  typedef enum logic [2:0] {StIdle, StFill, StRead, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] DrainLast = ADDR_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        seed_q;
  logic              verify_q;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W:0]   err_q;
  logic [ADDR_W-1:0] first_q;

  // Stage 0 loads on the same edge as addr_b, so stage READ_LAT lines up with q_b.
  logic              pv_q    [READ_LAT+1];
  logic [DATA_W-1:0] pexp_q  [READ_LAT+1];
  logic [ADDR_W-1:0] paddr_q [READ_LAT+1];

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        hi_byte;
  logic [DATA_W-1:0] cur_pat;
  logic              mismatch;
  logic [ADDR_W:0]   err_d;

  // Current address/pattern and the compare result for the word leaving the delay line
  always_comb begin
    cur_addr = base_q + idx_q;
    hi_byte  = seed_q + idx_q[7:0];
    cur_pat  = DATA_W'({hi_byte, TAG});
    mismatch = pv_q[READ_LAT] && (q_b_i != pexp_q[READ_LAT]);
    err_d    = err_q + (ADDR_W+1)'(mismatch);
  end

  // Sequencer FSM with registered port-B drive, compare delay line and results
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      base_q   <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      seed_q   <= '0;
      verify_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= '0;
      for (int i = 0; i <= READ_LAT; i++) begin
        pv_q[i]    <= 1'b0;
        pexp_q[i]  <= '0;
        paddr_q[i] <= '0;
      end
    end else begin
      pv_q[0]    <= 1'b0;
      pexp_q[0]  <= '0;
      paddr_q[0] <= '0;
      for (int i = 1; i <= READ_LAT; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pexp_q[i]  <= pexp_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
      end

      if (mismatch) begin
        err_q <= err_d;
        if (err_q == '0) begin
          first_q <= paddr_q[READ_LAT];
        end
      end

      done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          we_q   <= 1'b0;
          addr_q <= '0;
          data_q <= '0;
          busy_q <= 1'b0;
          if (start_i) begin
            base_q   <= base_addr_i;
            seed_q   <= seed_i;
            verify_q <= verify_en_i;
            // 0 means a full 4096-word sweep; anything above 4096 is clamped to it
            if (count_i == '0 || count_i[ADDR_W]) begin
              last_q <= '1;
            end else begin
              last_q <= count_i[ADDR_W-1:0] - AddrOne;
            end
            idx_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StFill;
          end
        end

        StFill: begin
          we_q   <= 1'b1;
          addr_q <= cur_addr;
          data_q <= cur_pat;
          if (idx_q == last_q) begin
            idx_q   <= '0;
            state_q <= verify_q ? StRead : StDone;
          end else begin
            idx_q <= idx_q + AddrOne;
          end
        end

        StRead: begin
          we_q       <= 1'b0;
          addr_q     <= cur_addr;
          data_q     <= '0;
          pv_q[0]    <= 1'b1;
          pexp_q[0]  <= cur_pat;
          paddr_q[0] <= cur_addr;
          if (idx_q == last_q) begin
            idx_q   <= '0;
            state_q <= StDrain;
          end else begin
            idx_q <= idx_q + AddrOne;
          end
        end

        StDrain: begin
          we_q   <= 1'b0;
          addr_q <= '0;
          data_q <= '0;
          if (idx_q == DrainLast) begin
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + AddrOne;
          end
        end

        StDone: begin
          we_q    <= 1'b0;
          addr_q  <= '0;
          data_q  <= '0;
          done_q  <= 1'b1;
          // The last read is compared on this same edge, so use the updated count
          pass_q  <= (err_d == '0);
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign we_b_o           = we_q;
  assign addr_b_o         = addr_q;
  assign data_b_o         = data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_ram_fill_verify_ctrl.sv
// Bench for ram_fill_verify_ctrl: instance A (READ_LAT=1) and instance B (READ_LAT=3),
// each with a behavioural RAM. A cycle-level model derived from the run parameters
// predicts every output; directed literal checks pin key cycles.
module tb_ram_fill_verify_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic        a_rst, a_start, a_ver;
  logic [11:0] a_base;
  logic [12:0] a_cnt;
  logic [7:0]  a_seed;
  logic [15:0] a_data, a_q;
  logic [11:0] a_addr;
  logic        a_we, a_busy, a_done, a_pass;
  logic [12:0] a_err;
  logic [11:0] a_first;

  // Instance B signals
  logic        b_rst, b_start, b_ver;
  logic [11:0] b_base;
  logic [12:0] b_cnt;
  logic [7:0]  b_seed;
  logic [15:0] b_data, b_q;
  logic [11:0] b_addr;
  logic        b_we, b_busy, b_done, b_pass;
  logic [12:0] b_err;
  logic [11:0] b_first;

  ram_fill_verify_ctrl #(.ADDR_W(12), .DATA_W(16), .READ_LAT(1), .TAG(8'hE8)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .base_addr_i(a_base), .count_i(a_cnt),
    .seed_i(a_seed), .verify_en_i(a_ver), .data_b_o(a_data), .addr_b_o(a_addr),
    .we_b_o(a_we), .q_b_i(a_q), .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
    .err_count_o(a_err), .first_err_addr_o(a_first)
  );

  ram_fill_verify_ctrl #(.ADDR_W(12), .DATA_W(16), .READ_LAT(3), .TAG(8'hE8)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .base_addr_i(b_base), .count_i(b_cnt),
    .seed_i(b_seed), .verify_en_i(b_ver), .data_b_o(b_data), .addr_b_o(b_addr),
    .we_b_o(b_we), .q_b_i(b_q), .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
    .err_count_o(b_err), .first_err_addr_o(b_first)
  );

  // RAM models: fault injection and read latency are set per instance
  int          lm         [2];
  logic        fault_en   [2];
  int          fault_addr [2];
  logic        mem_clr;

  logic [15:0] a_mem [4096];
  logic [15:0] a_rd  [3];
  logic [15:0] b_mem [4096];
  logic [15:0] b_rd  [3];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) a_mem[i] <= 16'h0000;
    end else if (a_we === 1'b1) begin
      a_mem[a_addr] <= a_data;
    end
    a_rd[0] <= (fault_en[0] && int'(a_addr) == fault_addr[0]) ? 16'h0000 : a_mem[a_addr];
    a_rd[1] <= a_rd[0];
    a_rd[2] <= a_rd[1];
  end
  assign a_q = a_rd[lm[0]-1];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) b_mem[i] <= 16'h0000;
    end else if (b_we === 1'b1) begin
      b_mem[b_addr] <= b_data;
    end
    b_rd[0] <= (fault_en[1] && int'(b_addr) == fault_addr[1]) ? 16'h0000 : b_mem[b_addr];
    b_rd[1] <= b_rd[0];
    b_rd[2] <= b_rd[1];
  end
  assign b_q = b_rd[lm[1]-1];

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 50)
        $display("FAIL %s [inst %0d cyc %0d]: got 0x%0h expected 0x%0h", name, id, cyc, act, exp);
    end
  endtask

  // Model state per instance
  int          dut_lat [2];
  logic [15:0] ref_mem [2][4096];
  logic        m_valid [2];
  int          m_c0    [2];
  int          m_n     [2];
  int          m_base  [2];
  int          m_seed  [2];
  logic        m_ver   [2];
  int          m_e     [2];
  int          r_pass  [2];
  int          r_err   [2];
  int          r_first [2];
  logic        check_en = 1'b0;

  function automatic int pat(input int seed, input int i);
    return (((seed + i) % 256) * 256) + 'hE8;
  endfunction

  // Address on port B during run-relative cycle t (0 outside the fill/read windows)
  function automatic int port_addr(input int id, input int t);
    if (t >= 1 && t <= m_n[id]) return (m_base[id] + t - 1) % 4096;
    if (m_ver[id] && t > m_n[id] && t <= 2 * m_n[id]) return (m_base[id] + t - m_n[id] - 1) % 4096;
    return 0;
  endfunction

  task automatic check_inst(input int id, input logic we, input logic [11:0] addr,
                            input logic [15:0] data, input logic busy, input logic done,
                            input logic pass, input logic [12:0] errc, input logic [11:0] first);
    int d;
    logic e_we, e_busy, e_done;
    logic [11:0] e_addr;
    logic [15:0] e_data;
    d = cyc - m_c0[id];
    e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
    if (m_valid[id] && d >= 0 && d <= m_e[id]) begin
      e_busy = 1'b1;
      e_done = (d == m_e[id]);
      e_addr = 12'(port_addr(id, d));
      if (d >= 1 && d <= m_n[id]) begin
        e_we   = 1'b1;
        e_data = 16'(pat(m_seed[id], d - 1));
      end
      if (d == 0) begin
        chk("err_count_cleared", id, 32'(errc), 0);
        chk("first_err_cleared", id, 32'(first), 0);
      end
      if (d < m_e[id]) begin
        chk("pass_low_in_run", id, 32'(pass), 0);
      end else begin
        chk("pass", id, 32'(pass), r_pass[id]);
        chk("err_count", id, 32'(errc), r_err[id]);
        chk("first_err_addr", id, 32'(first), r_first[id]);
      end
    end else begin
      chk("pass_hold", id, 32'(pass), r_pass[id]);
      chk("err_count_hold", id, 32'(errc), r_err[id]);
      chk("first_err_hold", id, 32'(first), r_first[id]);
    end
    chk("we_b", id, 32'(we), 32'(e_we));
    chk("addr_b", id, 32'(addr), 32'(e_addr));
    chk("data_b", id, 32'(data), 32'(e_data));
    chk("busy", id, 32'(busy), 32'(e_busy));
    chk("done", id, 32'(done), 32'(e_done));
  endtask

  // Single compare process, sampling on the falling edge
  always @(negedge clk) begin
    if (check_en) begin
      check_inst(0, a_we, a_addr, a_data, a_busy, a_done, a_pass, a_err, a_first);
      check_inst(1, b_we, b_addr, b_data, b_busy, b_done, b_pass, b_err, b_first);
    end
  end

  int a_wr = 0;
  always @(negedge clk) if (a_we === 1'b1) a_wr <= a_wr + 1;

  // Launch a run; must be called just after a falling edge. Start is sampled next rise.
  task automatic go(input int id, input int base, input int cnt, input int seed, input logic ver);
    int n, t, a, v, err, first;
    n = (cnt == 0) ? 4096 : cnt;
    m_valid[id] = 1'b1;
    m_c0[id]    = cyc + 1;
    m_n[id]     = n;
    m_base[id]  = base;
    m_seed[id]  = seed;
    m_ver[id]   = ver;
    m_e[id]     = ver ? (2 * n + dut_lat[id] + 1) : (n + 1);
    for (int i = 0; i < n; i++) ref_mem[id][(base + i) % 4096] = 16'(pat(seed, i));
    err = 0;
    first = 0;
    if (ver) begin
      for (int k = 0; k < n; k++) begin
        // The word the DUT compares for read k is the RAM response lm cycles after
        // whatever address was on the port at cycle n+1+k+READ_LAT-lm.
        t = n + 1 + k + dut_lat[id] - lm[id];
        a = port_addr(id, t);
        v = (fault_en[id] && a == fault_addr[id]) ? 0 : int'(ref_mem[id][a]);
        if (v != pat(seed, k)) begin
          if (err == 0) first = (base + k) % 4096;
          err++;
        end
      end
    end
    r_err[id]   = err;
    r_first[id] = first;
    r_pass[id]  = (err == 0) ? 1 : 0;
    if (id == 0) begin
      a_base = 12'(base); a_cnt = 13'(cnt); a_seed = 8'(seed); a_ver = ver; a_start = 1'b1;
    end else begin
      b_base = 12'(base); b_cnt = 13'(cnt); b_seed = 8'(seed); b_ver = ver; b_start = 1'b1;
    end
    @(negedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Advance to just after the falling edge of run-relative cycle d
  task automatic wait_d(input int id, input int d);
    while (cyc < m_c0[id] + d) begin
      @(negedge clk); #1;
    end
  endtask

  int wr0;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_base = '0; a_cnt = '0; a_seed = '0; a_ver = 1'b0;
    b_base = '0; b_cnt = '0; b_seed = '0; b_ver = 1'b0;
    mem_clr = 1'b1;
    dut_lat[0] = 1; dut_lat[1] = 3;
    lm[0] = 1; lm[1] = 3;
    for (int id = 0; id < 2; id++) begin
      fault_en[id] = 1'b0; fault_addr[id] = 0;
      m_valid[id] = 1'b0; m_c0[id] = 0; m_n[id] = 0; m_base[id] = 0; m_seed[id] = 0;
      m_ver[id] = 1'b0; m_e[id] = 0; r_pass[id] = 0; r_err[id] = 0; r_first[id] = 0;
      for (int i = 0; i < 4096; i++) ref_mem[id][i] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0; mem_clr = 1'b0;
    chk("reset_busy", 0, 32'(a_busy), 0);
    chk("reset_we", 0, 32'(a_we), 0);
    chk("reset_pass", 1, 32'(b_pass), 0);
    check_en = 1'b1;

    // Basic fill+verify
    go(0, 'h010, 4, 'h44, 1'b1);
    wait_d(0, 3);
    chk("t1_write2_addr", 0, 32'(a_addr), 32'h012);
    chk("t1_write2_data", 0, 32'(a_data), 32'h46E8);
    wait_d(0, 6);
    chk("t1_read1_addr", 0, 32'(a_addr), 32'h011);
    chk("t1_read1_we", 0, 32'(a_we), 0);
    wait_d(0, 10);
    chk("t1_done_cycle10", 0, 32'(a_done), 1);
    wait_d(0, 11);
    chk("t1_pass", 0, 32'(a_pass), 1);
    chk("t1_err", 0, 32'(a_err), 0);
    chk("t1_busy_low", 0, 32'(a_busy), 0);

    // Address wrap
    go(0, 'hFFE, 4, 'hFE, 1'b1);
    wait_d(0, 3);
    chk("t2_wrap_addr", 0, 32'(a_addr), 32'h000);
    chk("t2_wrap_data", 0, 32'(a_data), 32'h00E8);
    wait_d(0, 4);
    chk("t2_last_data", 0, 32'(a_data), 32'h01E8);
    wait_d(0, 11);
    chk("t2_pass", 0, 32'(a_pass), 1);

    // Fault injection at 0x012
    fault_en[0] = 1'b1; fault_addr[0] = 'h012;
    go(0, 'h010, 4, 'h44, 1'b1);
    wait_d(0, 11);
    chk("t3_err", 0, 32'(a_err), 1);
    chk("t3_first", 0, 32'(a_first), 32'h012);
    chk("t3_pass", 0, 32'(a_pass), 0);
    fault_en[0] = 1'b0;

    // count=0 fill-only full sweep
    wr0 = a_wr;
    go(0, 'h000, 0, 'h00, 1'b0);
    wait_d(0, 4096);
    chk("t4_last_addr", 0, 32'(a_addr), 32'hFFF);
    wait_d(0, 4097);
    chk("t4_done_cycle", 0, 32'(a_done), 1);
    chk("t4_we_off", 0, 32'(a_we), 0);
    wait_d(0, 4098);
    chk("t4_write_count", 0, 32'(a_wr - wr0), 4096);
    chk("t4_pass", 0, 32'(a_pass), 1);

    // Start while busy is ignored
    go(0, 'h020, 8, 'h30, 1'b1);
    wait_d(0, 2);
    a_base = 12'h777; a_cnt = 13'd3; a_seed = 8'h99; a_ver = 1'b0; a_start = 1'b1;
    @(negedge clk); #1;
    a_start = 1'b0;
    wait_d(0, 19);
    chk("t5_ignored_pass", 0, 32'(a_pass), 1);

    // Reset mid-run
    go(0, 'h040, 8, 'h50, 1'b1);
    wait_d(0, 5);
    a_rst = 1'b1;
    m_valid[0] = 1'b0; r_pass[0] = 0; r_err[0] = 0; r_first[0] = 0;
    @(negedge clk); #1;
    chk("t5_rst_we", 0, 32'(a_we), 0);
    chk("t5_rst_busy", 0, 32'(a_busy), 0);
    a_rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    chk("t5_no_done", 0, 32'(a_done), 0);

    // READ_LAT=3, aligned RAM
    go(1, 'h100, 2, 'h10, 1'b1);
    wait_d(1, 8);
    chk("t6_done_cycle8", 1, 32'(b_done), 1);
    wait_d(1, 9);
    chk("t6_pass", 1, 32'(b_pass), 1);

    // RAM answers one cycle early
    lm[1] = 2;
    go(1, 'h100, 2, 'h10, 1'b1);
    wait_d(1, 9);
    chk("t6_early_err", 1, 32'(b_err), 2);
    chk("t6_early_pass", 1, 32'(b_pass), 0);
    chk("t6_early_first", 1, 32'(b_first), 32'h100);

    repeat (4) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
